// File: rtl/ads_pkg.sv
// Shared types and constants for the ADS frame scheduler: FSM states, header size
// and default geometry of one UDP payload.
package ads_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEADER,
    ST_WAIT_FRAME,
    ST_EMIT,
    ST_DONE
  } ads_state_e;

  localparam int HDR_BYTES             = 4;
  localparam int DEF_LANE_COUNT        = 8;
  localparam int DEF_BITS_PER_PACKET   = 24;
  localparam int DEF_FRAMES_PER_PACKET = 16;

endpackage

// File: rtl/ads_frame_serializer.sv
// Holds one captured conversion frame and walks it out a byte at a time:
// lane 0 first, each lane MSB byte first.
module ads_frame_serializer
  import ads_pkg::*;
#(
  parameter int LANE_COUNT      = DEF_LANE_COUNT,
  parameter int BITS_PER_PACKET = DEF_BITS_PER_PACKET
) (
  input  logic                                       clk,
  input  logic                                       reset_n,
  input  logic                                       cap_i,
  input  logic                                       adv_i,
  input  logic [LANE_COUNT-1:0][BITS_PER_PACKET-1:0] lane_data_i,
  output logic [7:0]                                 byte_o,
  output logic                                       last_o
);

  localparam int BPL = BITS_PER_PACKET / 8;
  localparam int LW  = (LANE_COUNT > 1) ? $clog2(LANE_COUNT) : 1;
  localparam int BW  = (BPL > 1) ? $clog2(BPL) : 1;
  localparam logic [LW-1:0] LAST_LANE = LW'(LANE_COUNT - 1);
  localparam logic [BW-1:0] LAST_BYTE = BW'(BPL - 1);

  logic [LANE_COUNT-1:0][BITS_PER_PACKET-1:0] frame_q;
  logic [LW-1:0]                              lane_q;
  logic [BW-1:0]                              byte_q;
  logic [BITS_PER_PACKET-1:0]                 lane_w;
  logic [BITS_PER_PACKET-1:0]                 shifted;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_q <= '0;
      lane_q  <= '0;
      byte_q  <= '0;
    end else if (cap_i) begin
      frame_q <= lane_data_i;
      lane_q  <= '0;
      byte_q  <= '0;
    end else if (adv_i) begin
      if (byte_q == LAST_BYTE) begin
        byte_q <= '0;
        lane_q <= last_o ? '0 : lane_q + 1'b1;
      end else begin
        byte_q <= byte_q + 1'b1;
      end
    end
  end

  // Byte 0 of a lane is its MSB: shift the wanted byte to the top.
  assign lane_w  = frame_q[lane_q];
  assign shifted = lane_w << {byte_q, 3'b000};
  assign byte_o  = shifted[BITS_PER_PACKET-1 -: 8];
  assign last_o  = (lane_q == LAST_LANE) && (byte_q == LAST_BYTE);

endmodule

// File: rtl/ads_frame_scheduler.sv
// Packs ADC lane samples into UDP payloads: 4-byte sequence header followed by
// FRAMES_PER_PACKET frames, streamed as AXI-Stream bytes.
module ads_frame_scheduler
  import ads_pkg::*;
#(
  parameter int LANE_COUNT        = DEF_LANE_COUNT,
  parameter int BITS_PER_PACKET   = DEF_BITS_PER_PACKET,
  parameter int FRAMES_PER_PACKET = DEF_FRAMES_PER_PACKET
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic                                  enable,
  input  logic [LANE_COUNT-1:0]                 lane_valid,
  input  logic [LANE_COUNT*BITS_PER_PACKET-1:0] lane_data,
  output logic [LANE_COUNT-1:0]                 lane_ready,
  output logic [7:0]                            m_axis_tdata,
  output logic                                  m_axis_tvalid,
  input  logic                                  m_axis_tready,
  output logic                                  m_axis_tlast,
  output logic                                  busy,
  output logic [31:0]                           seq_num
);

  localparam int FW = (FRAMES_PER_PACKET > 1) ? $clog2(FRAMES_PER_PACKET) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES_PER_PACKET - 1);
  localparam logic [1:0]    HDR_LAST   = 2'(HDR_BYTES - 1);

  ads_state_e    state_q;
  logic          tvalid_q, busy_q;
  logic [31:0]   seq_q;
  logic [FW-1:0] frame_cnt_q;
  logic [1:0]    hdr_cnt_q;
  logic [31:0]   hdr_shift;
  logic [7:0]    ser_byte;
  logic          ser_last, all_valid, fire, cap;

  assign all_valid = &lane_valid;
  assign fire      = tvalid_q && m_axis_tready;
  assign cap       = (state_q == ST_WAIT_FRAME) && all_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      tvalid_q    <= 1'b0;
      busy_q      <= 1'b0;
      seq_q       <= '0;
      frame_cnt_q <= '0;
      hdr_cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (enable) begin
          state_q  <= ST_HEADER;
          tvalid_q <= 1'b1;
          busy_q   <= 1'b1;
        end
        ST_HEADER: if (fire) begin
          if (hdr_cnt_q == HDR_LAST) begin
            hdr_cnt_q <= '0;
            state_q   <= ST_WAIT_FRAME;
            tvalid_q  <= 1'b0;
          end else begin
            hdr_cnt_q <= hdr_cnt_q + 1'b1;
          end
        end
        ST_WAIT_FRAME: if (all_valid) begin
          state_q  <= ST_EMIT;
          tvalid_q <= 1'b1;
        end
        ST_EMIT: if (fire && ser_last) begin
          tvalid_q <= 1'b0;
          if (frame_cnt_q == FRAME_LAST) begin
            state_q <= ST_DONE;
          end else begin
            frame_cnt_q <= frame_cnt_q + 1'b1;
            state_q     <= ST_WAIT_FRAME;
          end
        end
        ST_DONE: begin
          // enable is only sampled here, so a mid-packet drop never truncates
          seq_q       <= seq_q + 32'd1;
          frame_cnt_q <= '0;
          hdr_cnt_q   <= '0;
          if (enable) begin
            state_q  <= ST_HEADER;
            tvalid_q <= 1'b1;
          end else begin
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          tvalid_q <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  ads_frame_serializer #(
    .LANE_COUNT     (LANE_COUNT),
    .BITS_PER_PACKET(BITS_PER_PACKET)
  ) u_ser (
    .clk        (clk),
    .reset_n    (reset_n),
    .cap_i      (cap),
    .adv_i      ((state_q == ST_EMIT) && fire),
    .lane_data_i(lane_data),
    .byte_o     (ser_byte),
    .last_o     (ser_last)
  );

  assign hdr_shift = seq_q << {hdr_cnt_q, 3'b000};

  always_comb begin
    m_axis_tdata = 8'h00;
    if (state_q == ST_HEADER)    m_axis_tdata = hdr_shift[31:24];
    else if (state_q == ST_EMIT) m_axis_tdata = ser_byte;
  end

  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = (state_q == ST_EMIT) && ser_last && (frame_cnt_q == FRAME_LAST);
  assign lane_ready    = {LANE_COUNT{cap}};
  assign busy          = busy_q;
  assign seq_num       = seq_q;

endmodule

// File: tb/tb_ads_frame_scheduler.sv
// Randomized bench for ads_frame_scheduler: a byte-stream reference built from
// popped lane samples and a sequence counter, checked on every handshake.
module tb_ads_frame_scheduler;

  localparam int LC      = 8;
  localparam int BPP     = 24;
  localparam int FPP     = 16;
  localparam int BPL     = BPP / 8;
  localparam int PKT_LEN = 4 + FPP * LC * BPL;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              enable = 1'b0;
  logic              tready = 1'b1;
  logic [LC-1:0]     lane_valid = '0;
  logic [LC-1:0]     lane_ready;
  logic [LC*BPP-1:0] lane_data = '0;
  logic [7:0]        tdata;
  logic              tvalid, tlast, busy;
  logic [31:0]       seq_num;

  always #4 clk = ~clk;

  ads_frame_scheduler #(
    .LANE_COUNT(LC), .BITS_PER_PACKET(BPP), .FRAMES_PER_PACKET(FPP)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .lane_valid(lane_valid), .lane_data(lane_data), .lane_ready(lane_ready),
    .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
    .m_axis_tlast(tlast), .busy(busy), .seq_num(seq_num)
  );

  int          checks = 0, failures = 0;
  logic [31:0] exp_seq = '0;
  int          pkt_pos = 0, pkts_done = 0;
  logic [7:0]  fq[$];
  bit          prev_stall = 1'b0;
  logic [7:0]  prev_data = '0;
  logic        prev_last = 1'b0;
  bit          rnd_data = 1'b0, rnd_valid = 1'b0, rnd_rdy = 1'b0;
  int          hold7 = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic set_data();
    for (int l = 0; l < LC; l++)
      lane_data[l*BPP +: BPP] = rnd_data ? 24'($urandom) : {8'(l), 16'h0102};
  endtask

  // One clock: observe at negedge, then drive new inputs just after posedge.
  task automatic step();
    bit popped = 1'b0;
    logic [7:0] e;
    @(negedge clk);
    if (lane_valid != '1) chk("partial_no_pop", lane_ready, 0);
    if (lane_ready != '0) begin
      chk("pop_all", lane_ready, {LC{1'b1}});
      for (int l = 0; l < LC; l++)
        for (int b = 0; b < BPL; b++)
          fq.push_back(lane_data[l*BPP + BPP - 8 - 8*b +: 8]);
      popped = 1'b1;
    end
    if (tvalid && prev_stall) begin
      chk("stall_data", tdata, prev_data);
      chk("stall_last", tlast, prev_last);
    end
    if (tvalid && tready) begin
      if (pkt_pos < 4) begin
        e = exp_seq[8*(3-pkt_pos) +: 8];
        chk("hdr_byte", tdata, e);
      end else begin
        chk("frame_avail", fq.size() > 0, 1);
        if (fq.size() > 0) begin
          e = fq.pop_front();
          chk("frame_byte", tdata, e);
        end
      end
      chk("tlast", tlast, pkt_pos == PKT_LEN - 1);
      pkt_pos++;
      if (pkt_pos == PKT_LEN) begin
        chk("no_leftover", fq.size(), 0);
        pkt_pos = 0;
        exp_seq = exp_seq + 32'd1;
        pkts_done++;
      end
    end
    prev_stall = tvalid && !tready;
    prev_data  = tdata;
    prev_last  = tlast;
    @(posedge clk); #1;
    if (popped) begin
      set_data();
      if (rnd_valid) lane_valid = '0;
    end else if (rnd_valid) begin
      for (int l = 0; l < LC; l++) if ($urandom_range(1, 0) == 1) lane_valid[l] = 1'b1;
    end
    if (!rnd_valid) lane_valid = '1;
    if (hold7 > 0) begin
      lane_valid[LC-1] = 1'b0;
      hold7--;
    end
    tready = rnd_rdy ? 1'($urandom_range(1, 0)) : 1'b1;
  endtask

  task automatic run(input int npkt, input int drop_at, input int rst_at);
    int start = pkts_done;
    int budget = 20000;
    bit rst_done = 1'b0;
    enable = 1'b1;
    while (pkts_done - start < npkt && budget > 0 && !rst_done) begin
      step();
      budget--;
      if (pkts_done - start == npkt - 1 && pkt_pos >= drop_at) enable = 1'b0;
      if (rst_at > 0 && pkt_pos == rst_at) begin
        #2 reset_n = 1'b0;
        #1;
        chk("rst_tvalid", tvalid, 0);
        chk("rst_lane_ready", lane_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tlast", tlast, 0);
        chk("rst_tdata", tdata, 0);
        chk("rst_seq", seq_num, 0);
        exp_seq = '0; pkt_pos = 0; fq.delete(); prev_stall = 1'b0;
        enable = 1'b0;
        @(posedge clk); #2 reset_n = 1'b1;
        rst_done = 1'b1;
      end
    end
    chk("run_in_budget", budget > 0, 1);
    enable = 1'b0;
    tready = 1'b1;
  endtask

  task automatic idle_chk(input int n);
    repeat (n) step();
    chk("idle_no_restart", pkt_pos, 0);
    chk("idle_busy", busy, 0);
    chk("idle_tvalid", tvalid, 0);
    chk("seq_num", seq_num, exp_seq);
  endtask

  initial begin
    lane_valid = '1;
    set_data();
    #1;
    chk("reset_tvalid", tvalid, 0);
    chk("reset_tlast", tlast, 0);
    chk("reset_tdata", tdata, 0);
    chk("reset_lane_ready", lane_ready, 0);
    chk("reset_busy", busy, 0);
    chk("reset_seq", seq_num, 0);
    #10; @(posedge clk); #1 reset_n = 1'b1;
    idle_chk(3);

    // fixed lane pattern, full-rate sink
    run(1, 1, 0);
    idle_chk(5);
    chk("seq_after_first", seq_num, 1);

    // lane 7 held back while 0-6 are valid
    lane_valid = 8'h7F; hold7 = 10;
    run(1, 1, 0);
    idle_chk(5);

    // random backpressure, fixed data
    rnd_rdy = 1'b1;
    run(1, 1, 0);
    idle_chk(5);

    // fully random, enable dropped at byte 100
    rnd_data = 1'b1; rnd_valid = 1'b1;
    run(1, 100, 0);
    idle_chk(20);

    // back-to-back packets through DONE->HEADER
    run(2, 1, 0);
    idle_chk(5);

    // sequence wrap
    force dut.seq_q = 32'hFFFF_FFFF;
    @(posedge clk); #1 release dut.seq_q;
    exp_seq = 32'hFFFF_FFFF;
    chk("seq_preload", seq_num, 32'hFFFF_FFFF);
    run(1, 1, 0);
    idle_chk(5);
    chk("seq_wrap", seq_num, 0);

    // reset mid-packet, then a fresh packet from sequence 0
    run(1, 1, 200);
    idle_chk(5);
    run(1, 1, 0);
    idle_chk(5);
    chk("seq_after_reset_pkt", seq_num, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
